seg7_shift_receiver: RTL
========================

Name: seg7_shift_receiver

Overview:
- Receiving end of the 4-bit serial display bus that drives the board's 64-bit segment shift-register chain.
- Oversamples the bus with the system clock, deserializes one frame and checks its length.
- Presents the captured 64-bit segment pattern with a one-cycle valid strobe.
- Used as a loopback monitor, a second-board display bridge, and a verification checker for the display path.

Parameters:
WIDTH, 64, frame length in bits; multiple of 8, one byte per digit.
CNT_W, $clog2(WIDTH)+1, bit-counter width; derived, never overridden.

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  reset; synchronous, active-high
sin  in  4  serial bus: sin[3]=sclk, sin[2]=sdat, sin[1]=sclr_n (active-low clear), sin[0]=sen (frame enable)
pattern  out  WIDTH  last good frame; first received bit at pattern[WIDTH-1]
frame_valid  out  1  one-cycle pulse when pattern updates
frame_err  out  1  one-cycle pulse when a frame ends with wrong bit count
overrun  out  1  sticky; set on a shift beyond WIDTH bits; cleared by rst or sclr_n low
busy  out  1  high while FSM in SHIFT
frame_cnt  out  16  count of good frames; wraps 0xFFFF->0

Behaviour:
- Reset values (rst high at a clk edge): pattern=0, frame_valid=0, frame_err=0, overrun=0, busy=0, frame_cnt=0, shift register=0, bit count=0, FSM=IDLE, edge-history flops=0.
- Input stage: sin is registered into s_cur every cycle; s_prev holds the previous s_cur.
  - Rising edge of a bus bit: s_prev=0, s_cur=1.
  - Falling edge of a bus bit: s_prev=1, s_cur=0.
  - The minimum bus phase width is 2 clk cycles (3 with the optional feature); narrower pulses may be missed.
- FSM states: IDLE, SHIFT.
  - IDLE -> SHIFT on a sen rising edge; bit count cleared to 0.
  - SHIFT -> IDLE on a sen falling edge; the frame is evaluated in the same cycle.
- Shift, in SHIFT only, on an sclk rising edge:
  - sreg <= {sreg[WIDTH-2:0], sdat}.
  - If bit count < WIDTH, bit count increments. If bit count == WIDTH, it saturates and overrun is set.
  - sclk edges in IDLE are ignored.
- Clear: while sclr_n=0 (level), sreg, bit count and overrun are zeroed.
  - Clear has priority over a shift in the same cycle.
  - FSM state and pattern are unaffected.
- Frame evaluation, on the sen falling edge:
  - If bit count == WIDTH and overrun=0: pattern <= sreg, frame_valid=1 for one cycle, frame_cnt+1.
  - Otherwise: frame_err=1 for one cycle; pattern and frame_cnt unchanged.
  - Bit count returns to 0. overrun remains set until cleared.
- Simultaneous events:
  - An sclk rising edge coinciding with the sen falling edge is NOT shifted; evaluation uses the prior count.
  - A sen rising edge in SHIFT cannot occur; a sen falling edge in IDLE is ignored.
- Latency:
  - frame_valid asserts on the 2nd clk edge after sin[0] goes low (the registered input stage, then the registered output).
  - With the optional feature it asserts on the 4th edge.
- Reset mid-frame: everything returns to reset values immediately. The remaining bits of the interrupted frame are ignored until the next sen rising edge.
- frame_valid and frame_err are never high together.

Optional Feature:
- Macro: SEG7RX_SYNC_EN.
- Defined: two metastability flops per sin bit ahead of the input stage; latency +2 cycles; minimum phase width 3 cycles. Required when sin comes from another board or another clock.
- Undefined: sin feeds the input stage directly; for same-clock loopback only.

Decomposition:
- Shared package seg7_pkg holds:
  - SIN_SCLK=3, SIN_SDAT=2, SIN_SCLR_N=1, SIN_SEN=0 (bus bit indices, also used by the transmit side).
  - The FSM state typedef {IDLE, SHIFT}.
  - SEG7_FRAME_W=64.
- Natural sub-module: seg7_bus_sampler, the optional synchronizer plus the s_cur/s_prev edge detector. It outputs rise[3:0] and fall[3:0] pulses plus the sdat and sclr_n levels.

Test Plan:
- Good frame: after rst, send 64 bits of 0xDEADBEEF_01234567 MSB first, each sclk phase 4 cycles. Expected: pattern=0xDEADBEEF01234567, one frame_valid pulse 2 cycles after sen falls, frame_cnt=1.
- Short frame: send 63 bits. Expected: frame_err pulse, frame_valid=0, pattern holds its previous value, frame_cnt unchanged.
- Long frame: send 65 bits. Expected: overrun=1 after the 65th sclk rise, frame_err pulse at sen fall. A following sclr_n low pulse clears overrun to 0.
- Clear mid-frame: 30 bits, sclr_n low 4 cycles, then 64 bits of 0xFFFFFFFFFFFFFFFF. Expected: frame_valid, pattern=all ones.
- Reset mid-frame: rst for 1 cycle after 20 bits. Expected: all outputs 0, busy=0; the remaining 44 bits with no new sen rise produce no pulses.
- Wrap: preload by running 65535 good frames (or force the counter) plus 1 more. Expected: frame_cnt=0. With SEG7RX_SYNC_EN defined, repeat the good-frame case and check frame_valid 4 cycles after the sen fall.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the 4-bit serial segment display bus, used by both
// the transmit and receive sides.
package seg7_pkg;

    localparam int SIN_SCLK   = 3;
    localparam int SIN_SDAT   = 2;
    localparam int SIN_SCLR_N = 1;
    localparam int SIN_SEN    = 0;

    localparam int SEG7_FRAME_W = 64;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } seg7_state_t;

    // Bit-counter width able to hold the full frame length itself.
    function automatic int seg7_cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/seg7_bus_sampler.sv
// Bus input stage: optional two-flop synchronizer (SEG7RX_SYNC_EN) followed by
// the s_cur/s_prev edge detector, producing one-cycle rise/fall pulses.
module seg7_bus_sampler
    import seg7_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sin,
    output logic [3:0] rise,
    output logic [3:0] fall,
    output logic       sdat,
    output logic       sclr_n
);

    logic [3:0] s_in;
    logic       in_valid;

`ifdef SEG7RX_SYNC_EN
    logic [3:0] sync1;
    logic [3:0] sync2;
    logic [1:0] sync_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1      <= '0;
            sync2      <= '0;
            sync_valid <= '0;
        end else begin
            sync1      <= sin;
            sync2      <= sync1;
            sync_valid <= {sync_valid[0], 1'b1};
        end
    end

    assign s_in     = sync2;
    assign in_valid = sync_valid[1];
`else
    assign s_in     = sin;
    assign in_valid = 1'b1;
`endif

    logic [3:0] s_cur;
    logic [3:0] s_prev;
    logic       cur_valid;
    logic       prev_valid;

    // The valid flags track which history flops hold real bus samples, so the
    // zeroed history after reset cannot fake a sen rise mid-frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_cur      <= '0;
            s_prev     <= '0;
            cur_valid  <= 1'b0;
            prev_valid <= 1'b0;
        end else begin
            s_cur      <= s_in;
            s_prev     <= s_cur;
            cur_valid  <= in_valid;
            prev_valid <= cur_valid;
        end
    end

    assign rise   = prev_valid ? (s_cur & ~s_prev) : 4'b0000;
    assign fall   = prev_valid ? (s_prev & ~s_cur) : 4'b0000;
    assign sdat   = s_cur[SIN_SDAT];
    assign sclr_n = cur_valid ? s_cur[SIN_SCLR_N] : 1'b1;

endmodule

// File: rtl/seg7_shift_receiver.sv
// Receiver for the serial segment display bus: deserializes one frame, checks
// its length and presents the pattern. Define SEG7RX_SYNC_EN for async inputs.
module seg7_shift_receiver
    import seg7_pkg::*;
#(
    parameter  int WIDTH = SEG7_FRAME_W,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       sin,
    output logic [WIDTH-1:0] pattern,
    output logic             frame_valid,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy,
    output logic [15:0]      frame_cnt
);

    logic [3:0] rise;
    logic [3:0] fall;
    logic       sdat;
    logic       sclr_n;

    seg7_bus_sampler u_sampler (
        .clk    (clk),
        .rst    (rst),
        .sin    (sin),
        .rise   (rise),
        .fall   (fall),
        .sdat   (sdat),
        .sclr_n (sclr_n)
    );

    logic unused_edges;
    assign unused_edges = ^{rise[SIN_SDAT], rise[SIN_SCLR_N],
                            fall[SIN_SCLK], fall[SIN_SDAT], fall[SIN_SCLR_N]};

    logic sen_rise;
    logic sen_fall;
    logic sclk_rise;

    assign sen_rise  = rise[SIN_SEN];
    assign sen_fall  = fall[SIN_SEN];
    assign sclk_rise = rise[SIN_SCLK];

    seg7_state_t      state_q;
    seg7_state_t      state_d;
    logic [WIDTH-1:0] sreg;
    logic [CNT_W-1:0] bit_cnt;
    logic             start_frame;
    logic             end_frame;
    logic             do_shift;
    logic             frame_good;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sen_rise) state_d = SHIFT;
            SHIFT:   if (sen_fall) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // An sclk rise landing on the sen fall is dropped so evaluation sees the
    // count as it stood before that edge.
    always_comb begin
        busy        = (state_q == SHIFT);
        start_frame = (state_q == IDLE) && sen_rise;
        end_frame   = (state_q == SHIFT) && sen_fall;
        do_shift    = (state_q == SHIFT) && sclk_rise && !sen_fall;
        frame_good  = (bit_cnt == CNT_W'(WIDTH)) && !overrun;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg    <= '0;
            bit_cnt <= '0;
            overrun <= 1'b0;
        end else if (!sclr_n) begin
            sreg    <= '0;
            bit_cnt <= '0;
            overrun <= 1'b0;
        end else if (start_frame || end_frame) begin
            bit_cnt <= '0;
        end else if (do_shift) begin
            sreg <= {sreg[WIDTH-2:0], sdat};
            if (bit_cnt == CNT_W'(WIDTH)) begin
                overrun <= 1'b1;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pattern     <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            if (end_frame) begin
                if (frame_good) begin
                    pattern     <= sreg;
                    frame_valid <= 1'b1;
                    frame_cnt   <= frame_cnt + 16'd1;
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

endmodule
